// File: rtl/tomasulo_regfile.sv
// ============================================================================
// Module   : tomasulo_regfile
// Purpose  : Architectural registers R1..R6 with a Tomasulo register-status
//            (Qi) table: issue-time rename, CDB retire, and two read ports
//            with same-cycle CDB forwarding.
// Option   : REGFILE_FLUSH_EN adds a flush input that clears every Qi tag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tomasulo_regfile #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
`ifdef REGFILE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              issue_valid,
    input  logic [3:0]        issue_rd,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [3:0]        rs_num,
    input  logic [3:0]        rt_num,
    output logic [DATA_W-1:0] rs_val,
    output logic [TAG_W-1:0]  rs_tag,
    output logic [DATA_W-1:0] rt_val,
    output logic [TAG_W-1:0]  rt_tag,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [5:0]        busy
);

    localparam int NREG = 6;

    // Index n holds architectural register R(n+1).
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [TAG_W-1:0]  qi_q   [NREG];
    logic [TAG_W-1:0]  qi_d   [NREG];

    logic w_flush;
`ifdef REGFILE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    logic w_cdb_live;
    assign w_cdb_live = cdb_valid && (cdb_tag != '0);

    // Retire is evaluated against the old Qi, then a same-cycle rename overrides the tag.
    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            regs_d[n] = regs_q[n];
            qi_d[n]   = qi_q[n];
            if (w_flush) begin
                qi_d[n] = '0;
            end else begin
                if (w_cdb_live && (qi_q[n] == cdb_tag)) begin
                    regs_d[n] = cdb_data;
                    qi_d[n]   = '0;
                end
                if (issue_valid && (issue_rd == 4'(n + 1))) begin
                    qi_d[n] = issue_tag;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= '0;
                qi_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= regs_d[n];
                qi_q[n]   <= qi_d[n];
            end
        end
    end

    logic [3:0]        rd_num [2];
    logic [DATA_W-1:0] rd_val [2];
    logic [TAG_W-1:0]  rd_tag [2];

    assign rd_num[0] = rs_num;
    assign rd_num[1] = rt_num;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_read_port
            always_comb begin
                rd_val[p] = '0;
                rd_tag[p] = '0;
                for (int n = 0; n < NREG; n++) begin
                    if (rd_num[p] == 4'(n + 1)) begin
                        if (qi_q[n] == '0) begin
                            rd_val[p] = regs_q[n];
                        end else if (cdb_valid && (cdb_tag == qi_q[n])) begin
                            rd_val[p] = cdb_data;
                        end else begin
                            rd_val[p] = regs_q[n];
                            rd_tag[p] = qi_q[n];
                        end
                    end
                end
            end
        end
    endgenerate

    assign rs_val = rd_val[0];
    assign rs_tag = rd_tag[0];
    assign rt_val = rd_val[1];
    assign rt_tag = rd_tag[1];

    assign r1 = regs_q[0];
    assign r2 = regs_q[1];
    assign r3 = regs_q[2];
    assign r4 = regs_q[3];
    assign r5 = regs_q[4];
    assign r6 = regs_q[5];

    generate
        for (genvar b = 0; b < NREG; b++) begin : g_busy
            assign busy[b] = (qi_q[b] != '0);
        end
    endgenerate

endmodule

`default_nettype wire
